// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball motion, wall/paddle collision, scoring and serve/game-over
// sequencing; every register advances only on a tick while game_state is play.
module pong_ball_engine #(
   parameter int          H_ACTIVE    = 640,
   parameter int          V_ACTIVE    = 480,
   parameter int          BALL_SIZE   = 16,
   parameter int          PADDLE_W    = 16,
   parameter int          PADDLE_H    = 80,
   parameter int          INIT_SPEED  = 1,
   parameter int          MAX_SPEED   = 4,
   parameter int          HITS_PER_UP = 4,
   parameter int          SERVE_TICKS = 60,
   parameter int          WIN_SCORE   = 9,
   parameter logic [11:0] BALL_RGB    = 12'hFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [9:0]  x_paddle1,
   input  logic [9:0]  y_paddle1,
   input  logic [9:0]  x_paddle2,
   input  logic [9:0]  y_paddle2,
   input  logic [1:0]  game_state,
   output logic        ball_on,
   output logic [11:0] rgb_ball,
   output logic [9:0]  x_ball,
   output logic [9:0]  y_ball,
   output logic [3:0]  p1_score,
   output logic [3:0]  p2_score,
   output logic        point_pulse,
   output logic        hit_pulse,
   output logic        game_over,
   output logic [1:0]  winner
);
   localparam logic [1:0] S_SERVE = 2'd0, S_PLAY = 2'd1, S_POINT = 2'd2, S_OVER = 2'd3;
   localparam int CW = $clog2(SERVE_TICKS + 1);
   localparam int HW = $clog2(HITS_PER_UP + 1);
   localparam logic signed [11:0] L_Z   = 12'sd0;
   localparam logic signed [11:0] L_HB  = 12'(BALL_SIZE / 2);
   localparam logic signed [11:0] L_HW  = 12'(PADDLE_W / 2);
   localparam logic signed [11:0] L_HH  = 12'(PADDLE_H / 2);
   localparam logic signed [11:0] L_HM1 = 12'(H_ACTIVE - 1);
   localparam logic signed [11:0] L_VM1 = 12'(V_ACTIVE - 1);
   localparam logic [9:0] L_XC   = 10'(H_ACTIVE / 2);
   localparam logic [9:0] L_YC   = 10'(V_ACTIVE / 2);
   localparam logic [3:0] L_WIN  = 4'(WIN_SCORE);
   localparam logic [2:0] L_INIT = 3'(INIT_SPEED);
   localparam logic [2:0] L_MAX  = 3'(MAX_SPEED);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [HW-1:0] r_hits;
   logic [9:0]    r_xb, r_yb;
   logic [2:0]    r_spd;
   logic [3:0]    r_p1, r_p2;
   logic [1:0]    r_winner;
   logic          r_dxn, r_dyn, r_hit, r_point;
   logic          w_adv, w_serve_done, w_top, w_bot, w_hit1, w_hit2, w_hit;
   logic          w_miss_l, w_miss_r, w_win, w_hits_wrap;
   logic [2:0]    w_spd_up;
   logic [3:0]    w_p1_inc, w_p2_inc;
   logic signed [11:0] w_x, w_y, w_spd, w_nx, w_ny, w_ny_c, w_nx_c;
   logic signed [11:0] w_p1x, w_p1y, w_p2x, w_p2y, w_bx, w_by;

   // All geometry is 12-bit signed so edge and paddle-face terms can go negative safely.
   assign w_adv        = tick && (game_state == 2'b01);
   assign w_serve_done = r_cnt == CW'(SERVE_TICKS - 1);
   assign w_x    = {2'b00, r_xb};
   assign w_y    = {2'b00, r_yb};
   assign w_spd  = {9'd0, r_spd};
   assign w_p1x  = {2'b00, x_paddle1};
   assign w_p1y  = {2'b00, y_paddle1};
   assign w_p2x  = {2'b00, x_paddle2};
   assign w_p2y  = {2'b00, y_paddle2};
   assign w_nx   = r_dxn ? w_x - w_spd : w_x + w_spd;
   assign w_ny   = r_dyn ? w_y - w_spd : w_y + w_spd;
   assign w_top  = (w_ny - L_HB) <= L_Z;
   assign w_bot  = (w_ny + L_HB) >= L_VM1;
   assign w_ny_c = w_top ? L_HB : w_bot ? L_VM1 - L_HB : w_ny;
   assign w_hit1 = r_dxn && ((w_nx - L_HB) <= (w_p1x + L_HW)) && ((w_x - L_HB) > (w_p1x + L_HW)) &&
                   ((w_ny_c - L_HB) <= (w_p1y + L_HH)) && ((w_ny_c + L_HB) >= (w_p1y - L_HH));
   assign w_hit2 = !r_dxn && ((w_nx + L_HB) >= (w_p2x - L_HW)) && ((w_x + L_HB) < (w_p2x - L_HW)) &&
                   ((w_ny_c - L_HB) <= (w_p2y + L_HH)) && ((w_ny_c + L_HB) >= (w_p2y - L_HH));
   assign w_hit    = w_hit1 || w_hit2;
   assign w_miss_l = !w_hit && ((w_nx - L_HB) <= L_Z);
   assign w_miss_r = !w_hit && !w_miss_l && ((w_nx + L_HB) >= L_HM1);
   assign w_nx_c   = w_hit1 ? w_p1x + L_HW + L_HB : w_hit2 ? w_p2x - L_HW - L_HB : w_nx;
   assign w_hits_wrap = r_hits == HW'(HITS_PER_UP - 1);
   assign w_spd_up = (r_spd < L_MAX) ? r_spd + 3'd1 : r_spd;
   assign w_p1_inc = (r_p1 < L_WIN) ? r_p1 + 4'd1 : r_p1;
   assign w_p2_inc = (r_p2 < L_WIN) ? r_p2 + 4'd1 : r_p2;
   assign w_win    = (r_p1 == L_WIN) || (r_p2 == L_WIN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_SERVE;
         r_cnt    <= '0;
         r_hits   <= '0;
         r_xb     <= L_XC;
         r_yb     <= L_YC;
         r_dxn    <= 1'b0;
         r_dyn    <= 1'b1;
         r_spd    <= L_INIT;
         r_p1     <= '0;
         r_p2     <= '0;
         r_hit    <= 1'b0;
         r_point  <= 1'b0;
         r_winner <= 2'b00;
      end else begin
         r_hit   <= 1'b0;
         r_point <= 1'b0;
         if (w_adv) begin
            case (r_state)
               S_SERVE: begin
                  r_cnt   <= w_serve_done ? '0 : r_cnt + 1'b1;
                  r_state <= w_serve_done ? S_PLAY : S_SERVE;
               end
               S_PLAY: begin
                  r_xb  <= 10'(w_nx_c);
                  r_yb  <= 10'(w_ny_c);
                  r_dyn <= w_top ? 1'b0 : w_bot ? 1'b1 : r_dyn;
                  // A paddle hit takes priority over a miss detected in the same tick.
                  if (w_hit) begin
                     r_hit  <= 1'b1;
                     r_dxn  <= w_hit2;
                     r_hits <= w_hits_wrap ? '0 : r_hits + 1'b1;
                     r_spd  <= w_hits_wrap ? w_spd_up : r_spd;
                  end else if (w_miss_l || w_miss_r) begin
                     r_point <= 1'b1;
                     r_state <= S_POINT;
                     r_dxn   <= w_miss_l;
                     r_p1    <= w_miss_r ? w_p1_inc : r_p1;
                     r_p2    <= w_miss_l ? w_p2_inc : r_p2;
                  end
               end
               S_POINT: begin
                  r_xb     <= L_XC;
                  r_yb     <= L_YC;
                  r_spd    <= L_INIT;
                  r_hits   <= '0;
                  r_state  <= w_win ? S_OVER : S_SERVE;
                  r_winner <= !w_win ? 2'b00 : (r_p1 == L_WIN) ? 2'b01 : 2'b10;
               end
               default: ;
            endcase
         end
      end
   end

   assign w_bx        = {2'b00, x} - w_x;
   assign w_by        = {2'b00, y} - w_y;
   assign ball_on     = (w_bx <= L_HB) && (w_bx >= -L_HB) && (w_by <= L_HB) && (w_by >= -L_HB);
   assign rgb_ball    = BALL_RGB;
   assign x_ball      = r_xb;
   assign y_ball      = r_yb;
   assign p1_score    = r_p1;
   assign p2_score    = r_p2;
   assign point_pulse = r_point;
   assign hit_pulse   = r_hit;
   assign game_over   = r_state == S_OVER;
   assign winner      = r_winner;
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed game scenarios checked every cycle against an
// arithmetic model of the ball rules, plus hand-computed positions and scores.
module tb_pong_ball_engine;
   logic        clk = 1'b0, reset = 1'b0, tick = 1'b0;
   logic [9:0]  x = '0, y = '0;
   logic [9:0]  x_paddle1 = 10'd16, y_paddle1 = 10'd240, x_paddle2 = 10'd624, y_paddle2 = 10'd240;
   logic [1:0]  game_state = 2'b01;
   logic        ball_on, point_pulse, hit_pulse, game_over;
   logic [11:0] rgb_ball;
   logic [9:0]  x_ball, y_ball;
   logic [3:0]  p1_score, p2_score;
   logic [1:0]  winner;
   int n_chk = 0, n_fail = 0;
   int m_x, m_y, m_dx, m_dy, m_spd, m_hits, m_p1, m_p2, m_serve, m_win, m_nhits;
   bit m_pend, m_over, m_hitp, m_ptp;
   bit trk1 = 1'b1, trk2 = 1'b1;

   pong_ball_engine dut (
      .clk(clk), .reset(reset), .tick(tick), .x(x), .y(y),
      .x_paddle1(x_paddle1), .y_paddle1(y_paddle1), .x_paddle2(x_paddle2), .y_paddle2(y_paddle2),
      .game_state(game_state), .ball_on(ball_on), .rgb_ball(rgb_ball), .x_ball(x_ball), .y_ball(y_ball),
      .p1_score(p1_score), .p2_score(p2_score), .point_pulse(point_pulse), .hit_pulse(hit_pulse),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   function automatic int iabs(int v);
      return v < 0 ? -v : v;
   endfunction

   function automatic int clampi(int v);
      return v < 0 ? 0 : (v > 1023 ? 1023 : v);
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_x = 320; m_y = 240; m_dx = 1; m_dy = -1; m_spd = 1; m_hits = 0;
      m_p1 = 0; m_p2 = 0; m_serve = 60; m_win = 0; m_nhits = 0;
      m_pend = 0; m_over = 0; m_hitp = 0; m_ptp = 0;
   endtask

   // One qualified tick of the game rules, in plain integer arithmetic.
   task automatic m_step();
      int nx, ny, p1x, p1y, p2x, p2y;
      bit hit;
      p1x = int'(x_paddle1); p1y = int'(y_paddle1);
      p2x = int'(x_paddle2); p2y = int'(y_paddle2);
      if (m_over) return;
      if (m_pend) begin
         m_pend = 0; m_x = 320; m_y = 240; m_spd = 1; m_hits = 0;
         if (m_p1 == 9 || m_p2 == 9) begin
            m_over = 1;
            m_win = (m_p1 == 9) ? 1 : 2;
         end else m_serve = 60;
         return;
      end
      if (m_serve > 0) begin
         m_serve--;
         return;
      end
      nx = m_x + m_dx * m_spd;
      ny = m_y + m_dy * m_spd;
      if (ny - 8 <= 0) begin ny = 8; m_dy = 1; end
      else if (ny + 8 >= 479) begin ny = 471; m_dy = -1; end
      hit = 0;
      if (m_dx < 0 && nx - 8 <= p1x + 8 && m_x - 8 > p1x + 8 && ny - 8 <= p1y + 40 && ny + 8 >= p1y - 40) begin
         hit = 1; nx = p1x + 16; m_dx = 1;
      end else if (m_dx > 0 && nx + 8 >= p2x - 8 && m_x + 8 < p2x - 8 && ny - 8 <= p2y + 40 && ny + 8 >= p2y - 40) begin
         hit = 1; nx = p2x - 16; m_dx = -1;
      end
      if (hit) begin
         m_hitp = 1; m_nhits++; m_hits++;
         if (m_hits == 4) begin
            m_hits = 0;
            if (m_spd < 4) m_spd++;
         end
      end else if (nx - 8 <= 0) begin
         if (m_p2 < 9) m_p2++;
         m_dx = -1; m_ptp = 1; m_pend = 1;
      end else if (nx + 8 >= 639) begin
         if (m_p1 < 9) m_p1++;
         m_dx = 1; m_ptp = 1; m_pend = 1;
      end
      m_x = nx; m_y = ny;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) m_reset();
         else begin
            m_hitp = 0; m_ptp = 0;
            if (tick && game_state == 2'b01) m_step();
         end
      end
   end

   // Pixel probe wanders around the ball; paddles either track the ball or park off-screen.
   initial forever begin
      @(posedge clk); #2;
      x = 10'(clampi(m_x + int'($urandom_range(0, 24)) - 12));
      y = 10'(clampi(m_y + int'($urandom_range(0, 24)) - 12));
      y_paddle1 = trk1 ? 10'(m_y) : 10'd1000;
      y_paddle2 = trk2 ? 10'(m_y) : 10'd1000;
   end

   always @(negedge clk) begin
      chk("x_ball", int'(x_ball), m_x);
      chk("y_ball", int'(y_ball), m_y);
      chk("p1_score", int'(p1_score), m_p1);
      chk("p2_score", int'(p2_score), m_p2);
      chk("hit_pulse", int'(hit_pulse), int'(m_hitp));
      chk("point_pulse", int'(point_pulse), int'(m_ptp));
      chk("game_over", int'(game_over), int'(m_over));
      chk("winner", int'(winner), m_win);
      chk("ball_on", int'(ball_on), int'(iabs(int'(x) - m_x) <= 8 && iabs(int'(y) - m_y) <= 8));
      chk("rgb_ball", int'(rgb_ball), 'hFFF);
   end

   task automatic ticks_exact(int n);
      @(posedge clk); #2 tick = 1'b1;
      repeat (n) @(posedge clk);
      #2 tick = 1'b0;
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk); #2 tick = ($urandom_range(0, 3) != 0);
      end
      tick = 1'b0;
   endtask

   function automatic bit ev(int kind);
      case (kind)
         0: return hit_pulse;
         1: return point_pulse;
         2: return game_over;
         default: return p2_score == 4'd5;
      endcase
   endfunction

   task automatic wait_ev(string nm, int kind, int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk); #2;
         if (ev(kind)) begin ok = 1; tick = 1'b0; end
         else tick = ($urandom_range(0, 3) != 0);
      end
      chk(nm, int'(ok), 1);
   endtask

   task automatic check_reset_values(string tag);
      chk({tag, "_x"}, int'(x_ball), 320);
      chk({tag, "_y"}, int'(y_ball), 240);
      chk({tag, "_p1"}, int'(p1_score), 0);
      chk({tag, "_p2"}, int'(p2_score), 0);
      chk({tag, "_hit"}, int'(hit_pulse), 0);
      chk({tag, "_point"}, int'(point_pulse), 0);
      chk({tag, "_over"}, int'(game_over), 0);
      chk({tag, "_winner"}, int'(winner), 0);
   endtask

   initial begin
      int x0, y0;
      repeat (3) @(posedge clk);
      #2 check_reset_values("reset");
      reset = 1'b1;
      ticks_exact(60);
      chk("serve_hold_x", int'(x_ball), 320);
      chk("serve_hold_y", int'(y_ball), 240);
      ticks_exact(1);
      chk("first_move_x", int'(x_ball), 321);
      chk("first_move_y", int'(y_ball), 239);
      wait_ev("wait_hit_p2", 0, 5000);
      chk("hit_p2_flush_x", int'(x_ball), 608);
      wait_ev("wait_hit_p1", 0, 5000);
      chk("hit_p1_flush_x", int'(x_ball), 32);
      for (int k = 0; k < 30 && m_nhits < 17; k++) wait_ev("wait_rally_hit", 0, 5000);
      chk("model_speed_saturated", m_spd, 4);
      wait_ev("wait_fast_hit", 0, 5000);
      x0 = int'(x_ball);
      ticks_exact(1);
      chk("speed4_step", iabs(int'(x_ball) - x0), 4);
      cyc(40);
      @(posedge clk); #2;
      x0 = int'(x_ball); y0 = int'(y_ball);
      game_state = 2'b00; tick = 1'b1;
      repeat (100) @(posedge clk);
      #2 game_state = 2'b11;
      repeat (20) @(posedge clk);
      #2 tick = 1'b0; game_state = 2'b01;
      chk("pause_x", int'(x_ball), x0);
      chk("pause_y", int'(y_ball), y0);
      ticks_exact(1);
      chk("resume_step", iabs(int'(x_ball) - x0), 4);
      for (int k = 0; k < 4 && !(hit_pulse && x_ball < 10'd320); k++) wait_ev("wait_p1_side", 0, 5000);
      trk1 = 1'b0; trk2 = 1'b0;
      wait_ev("wait_point", 1, 5000);
      chk("p1_first_point", int'(p1_score), 1);
      chk("p2_no_point", int'(p2_score), 0);
      ticks_exact(1);
      chk("recentre_x", int'(x_ball), 320);
      chk("recentre_y", int'(y_ball), 240);
      ticks_exact(60);
      chk("reserve_hold_x", int'(x_ball), 320);
      ticks_exact(1);
      chk("serve_toward_right", int'(x_ball), 321);
      wait_ev("wait_game_over", 2, 30000);
      chk("final_p1", int'(p1_score), 9);
      chk("final_winner", int'(winner), 1);
      x0 = int'(x_ball); y0 = int'(y_ball);
      ticks_exact(100);
      chk("frozen_x", int'(x_ball), x0);
      chk("frozen_y", int'(y_ball), y0);
      chk("frozen_over", int'(game_over), 1);
      @(posedge clk); #3 reset = 1'b0;
      #1 check_reset_values("reset_after_over");
      @(negedge clk); #2 reset = 1'b1;
      trk1 = 1'b0; trk2 = 1'b1;
      wait_ev("wait_p2_five", 3, 20000);
      cyc(150);
      chk("p2_five", int'(p2_score), 5);
      chk("in_flight", int'(x_ball != 10'd320), 1);
      @(posedge clk); #3 reset = 1'b0;
      #1 check_reset_values("reset_mid_play");
      @(negedge clk); #2 reset = 1'b1;
      cyc(20);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
